// File: rtl/q_deserial_reg.sv
// Serial-in/parallel-out word collector: one bit per handshake, finished word on a valid/ready output.
// Latency: out_valid rises the cycle after the last bit; bit_ready is low in IDLE/HOLD so HOLD backpressures the source.
module q_deserial_reg #(
  parameter int WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clr,
  input  logic                         i_start,
  input  logic                         i_dir,
  input  logic                         i_bit_in,
  input  logic                         i_bit_valid,
  output logic                         o_bit_ready,
  input  logic                         i_out_ready,
  output logic                         o_out_valid,
  output logic [WIDTH-1:0]             o_q,
  output logic [$clog2(WIDTH+1)-1:0]   o_count,
  output logic                         o_busy
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_count;
  logic             r_dir;
  logic             r_bit_ready;
  logic             r_out_valid;
  logic             r_busy;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_count     <= '0;
      r_dir       <= 1'b0;
      r_bit_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (i_clr) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_count     <= '0;
      r_bit_ready <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state     <= S_COLLECT;
            r_q         <= '0;
            r_count     <= '0;
            r_dir       <= i_dir;
            r_bit_ready <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (i_bit_valid) begin
            // dir 0 fills from the MSB end, dir 1 from the LSB end
            if (r_dir) r_q <= {r_q[WIDTH-2:0], i_bit_in};
            else       r_q <= {i_bit_in, r_q[WIDTH-1:1]};
            r_count <= r_count + CW'(1);
            if (r_count == LAST_IDX) begin
              r_state     <= S_HOLD;
              r_bit_ready <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_bit_ready <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_bit_ready = r_bit_ready;
  assign o_out_valid = r_out_valid;
  assign o_q         = r_q;
  assign o_count     = r_count;
  assign o_busy      = r_busy;

endmodule
